// File: rtl/comm_pkg.sv
`default_nettype none
// ==================================================================
// comm_pkg : shared types, defaults and frame helper for comm_master
// Rev 1.0
// ==================================================================
package comm_pkg;

   localparam int BAUD_CNT_DFLT = 109;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_HIGH = 2'd1,
      TX_LOW  = 2'd2
   } tx_state_t;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_RECV = 1'b1
   } rx_state_t;

   // Line level for position idx of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
   function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
      if (idx == 4'd0) begin
         return 1'b0;
      end else if (idx <= 4'd8) begin
         return data[3'(idx - 4'd1)];
      end else begin
         return 1'b1;
      end
   endfunction

endpackage : comm_pkg
`default_nettype wire

// File: rtl/comm_master_if.sv
`default_nettype none
// ==================================================================
// comm_master_if : host command / response bus of comm_master
// Rev 1.0  (resp_timeout present with COMM_RESP_TIMEOUT_EN)
// ==================================================================
interface comm_master_if;

   logic [15:0] cmd;
   logic        snd_cmd;
   logic        TX;
   logic        RX;
   logic        cmd_cmplt;
   logic [7:0]  resp;
   logic        resp_cmplt;
   logic        clr_rdy;
`ifdef COMM_RESP_TIMEOUT_EN
   logic        resp_timeout;

   modport master (
      input  cmd, snd_cmd, RX, clr_rdy,
      output TX, cmd_cmplt, resp, resp_cmplt, resp_timeout
   );

   modport slave (
      output cmd, snd_cmd, RX, clr_rdy,
      input  TX, cmd_cmplt, resp, resp_cmplt, resp_timeout
   );
`else
   modport master (
      input  cmd, snd_cmd, RX, clr_rdy,
      output TX, cmd_cmplt, resp, resp_cmplt
   );

   modport slave (
      output cmd, snd_cmd, RX, clr_rdy,
      input  TX, cmd_cmplt, resp, resp_cmplt
   );
`endif

endinterface : comm_master_if
`default_nettype wire

// File: rtl/comm_uart_rx.sv
`default_nettype none
// ==================================================================
// comm_uart_rx : 8N1 receiver with 2-flop sync and mid-bit sampling
// Rev 1.0
// ==================================================================
module comm_uart_rx
   import comm_pkg::*;
#(
   parameter int BAUD_CNT = BAUD_CNT_DFLT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   input  logic       i_clr_rdy,
   output logic [7:0] o_data,
   output logic       o_rdy
);

   localparam int              CNT_W  = $clog2(BAUD_CNT);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(BAUD_CNT / 2 - 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD_CNT - 1);

   logic             r_sync1, r_sync2, r_prev;
   rx_state_t        r_state, w_nxt_state;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic [3:0]       r_bit, w_nxt_bit;
   logic [7:0]       r_shift, w_nxt_shift;
   logic [7:0]       r_data;
   logic             r_rdy;
   logic             w_start;
   logic             w_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_start = (r_state == RX_IDLE) && r_prev && !r_sync2;
   assign w_last  = (r_state == RX_RECV) && (r_cnt == '0) && (r_bit == 4'd9);

   // Sample 0 is the start bit, 1..8 data, 9 the (unchecked) stop bit.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_bit   = r_bit;
      w_nxt_shift = r_shift;
      case (r_state)
         RX_IDLE: begin
            if (w_start) begin
               w_nxt_state = RX_RECV;
               w_nxt_cnt   = C_HALF;
               w_nxt_bit   = 4'd0;
            end
         end
         RX_RECV: begin
            if (r_cnt == '0) begin
               w_nxt_cnt = C_FULL;
               w_nxt_bit = r_bit + 4'd1;
               if ((r_bit >= 4'd1) && (r_bit <= 4'd8)) begin
                  w_nxt_shift = {r_sync2, r_shift[7:1]};
               end
               if (r_bit == 4'd9) begin
                  w_nxt_state = RX_IDLE;
               end
            end else begin
               w_nxt_cnt = r_cnt - CNT_W'(1);
            end
         end
         default: w_nxt_state = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= 4'd0;
         r_shift <= 8'h00;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_bit   <= w_nxt_bit;
         r_shift <= w_nxt_shift;
      end
   end

   // Setting on the stop sample takes priority over any clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data <= 8'h00;
         r_rdy  <= 1'b0;
      end else if (w_last) begin
         r_data <= r_shift;
         r_rdy  <= 1'b1;
      end else if (i_clr_rdy || w_start) begin
         r_rdy  <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_rdy  = r_rdy;

endmodule : comm_uart_rx
`default_nettype wire

// File: rtl/comm_master.sv
`default_nettype none
// ==================================================================
// comm_master : UART host command master (2-byte cmd out, 1-byte resp in)
// Rev 1.0  (optional COMM_RESP_TIMEOUT_EN adds resp_timeout)
// ==================================================================
module comm_master
   import comm_pkg::*;
#(
   parameter int BAUD_CNT = BAUD_CNT_DFLT
`ifdef COMM_RESP_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CLKS = 1000000
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   comm_master_if.master bus
);

   localparam int              CNT_W  = $clog2(BAUD_CNT);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD_CNT - 1);

   tx_state_t        r_state, w_nxt_state;
   logic [CNT_W-1:0] r_baud, w_nxt_baud;
   logic [3:0]       r_bit, w_nxt_bit;
   logic [15:0]      r_shadow, w_nxt_shadow;
   logic             r_tx, w_nxt_tx;
   logic             r_cmd_cmplt, w_nxt_cmd_cmplt;
   logic             w_accept;
   logic             w_tx_done;
   logic [7:0]       w_byte;
   logic [7:0]       w_resp;
   logic             w_resp_cmplt;

   assign w_accept = (r_state == TX_IDLE) && bus.snd_cmd;
   assign w_byte   = (r_state == TX_HIGH) ? r_shadow[15:8] : r_shadow[7:0];

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_baud      = r_baud;
      w_nxt_bit       = r_bit;
      w_nxt_shadow    = r_shadow;
      w_nxt_tx        = r_tx;
      w_nxt_cmd_cmplt = r_cmd_cmplt;
      w_tx_done       = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (w_accept) begin
               w_nxt_state     = TX_HIGH;
               w_nxt_shadow    = bus.cmd;
               w_nxt_cmd_cmplt = 1'b0;
               w_nxt_tx        = 1'b0;
               w_nxt_baud      = '0;
               w_nxt_bit       = 4'd0;
            end
         end
         TX_HIGH, TX_LOW: begin
            if (r_baud == C_FULL) begin
               w_nxt_baud = '0;
               if (r_bit == 4'd9) begin
                  // End of a stop bit: chain straight into the low byte's start bit.
                  w_nxt_bit = 4'd0;
                  if (r_state == TX_HIGH) begin
                     w_nxt_state = TX_LOW;
                     w_nxt_tx    = 1'b0;
                  end else begin
                     w_nxt_state     = TX_IDLE;
                     w_nxt_tx        = 1'b1;
                     w_nxt_cmd_cmplt = 1'b1;
                     w_tx_done       = 1'b1;
                  end
               end else begin
                  w_nxt_bit = r_bit + 4'd1;
                  w_nxt_tx  = frame_bit(w_byte, r_bit + 4'd1);
               end
            end else begin
               w_nxt_baud = r_baud + CNT_W'(1);
            end
         end
         default: w_nxt_state = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= TX_IDLE;
         r_baud      <= '0;
         r_bit       <= 4'd0;
         r_shadow    <= 16'h0000;
         r_tx        <= 1'b1;
         r_cmd_cmplt <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_baud      <= w_nxt_baud;
         r_bit       <= w_nxt_bit;
         r_shadow    <= w_nxt_shadow;
         r_tx        <= w_nxt_tx;
         r_cmd_cmplt <= w_nxt_cmd_cmplt;
      end
   end

   comm_uart_rx #(
      .BAUD_CNT (BAUD_CNT)
   ) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rx      (bus.RX),
      .i_clr_rdy (bus.clr_rdy),
      .o_data    (w_resp),
      .o_rdy     (w_resp_cmplt)
   );

   assign bus.TX         = r_tx;
   assign bus.cmd_cmplt  = r_cmd_cmplt;
   assign bus.resp       = w_resp;
   assign bus.resp_cmplt = w_resp_cmplt;

`ifdef COMM_RESP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

   logic            r_to_run;
   logic            r_timeout;
   logic            r_rdy_d;
   logic [TO_W-1:0] r_to_cnt;
   logic            w_resp_set;

   // A fresh response shows up as a rising edge even if resp_cmplt was left set.
   assign w_resp_set = w_resp_cmplt && !r_rdy_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_run  <= 1'b0;
         r_timeout <= 1'b0;
         r_rdy_d   <= 1'b0;
         r_to_cnt  <= '0;
      end else begin
         r_rdy_d <= w_resp_cmplt;
         if (w_accept) begin
            r_to_run  <= 1'b0;
            r_timeout <= 1'b0;
         end else if (w_tx_done) begin
            r_to_run <= 1'b1;
            r_to_cnt <= '0;
         end else if (r_to_run) begin
            if (w_resp_set) begin
               r_to_run <= 1'b0;
            end else if (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
               r_timeout <= 1'b1;
               r_to_run  <= 1'b0;
            end else begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
            end
         end
      end
   end

   assign bus.resp_timeout = r_timeout;
`endif

endmodule : comm_master
`default_nettype wire

// File: tb/tb_comm_master.sv
`default_nettype none
// ==================================================================
// tb_comm_master : directed self-checking bench for comm_master
// Rev 1.0
// ==================================================================
module tb_comm_master;

   localparam int B = 109;

   logic clk = 1'b0;
   logic rst_n;
   logic rx_drv;
   logic loop_en;
   int   total = 0;
   int   bad   = 0;

   logic [19:0] got;
   int          rise;
   logic        cc0;
   int          lows;
   int          rises;
   logic [7:0]  first;
   logic        prev;

   comm_master_if bus ();

   assign bus.RX = loop_en ? bus.TX : rx_drv;

   comm_master #(
      .BAUD_CNT (B)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command and records the line at every mid-bit point plus the cmd_cmplt rise time.
   task automatic send_and_capture(input logic [15:0] c, input logic poke,
                                   output logic [19:0] bits, output int rise_at,
                                   output logic cc_at0);
      bus.cmd     = c;
      bus.snd_cmd = 1'b1;
      @(negedge clk);
      bus.snd_cmd = 1'b0;
      bits    = '0;
      rise_at = -1;
      cc_at0  = bus.cmd_cmplt;
      for (int n = 0; n < 2300; n++) begin
         if (n > 0) @(negedge clk);
         if ((n >= B / 2) && (((n - B / 2) % B) == 0) && (((n - B / 2) / B) < 20))
            bits[(n - B / 2) / B] = bus.TX;
         if (poke && (n == 300)) begin
            bus.cmd     = 16'hFFFF;
            bus.snd_cmd = 1'b1;
         end
         if (poke && (n == 301)) bus.snd_cmd = 1'b0;
         if (bus.cmd_cmplt && (rise_at < 0)) rise_at = n;
      end
   endtask

   task automatic uart_bits(input logic [7:0] d);
      for (int k = 0; k < 9; k++) begin
         rx_drv = (k == 0) ? 1'b0 : d[k - 1];
         repeat (B) @(negedge clk);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      rx_drv      = 1'b1;
      loop_en     = 1'b0;
      bus.cmd     = 16'h0000;
      bus.snd_cmd = 1'b0;
      bus.clr_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", bus.TX, 1);
      chk("rst_cmd_cmplt", bus.cmd_cmplt, 0);
      chk("rst_resp_cmplt", bus.resp_cmplt, 0);
      chk("rst_resp", bus.resp, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Write 4A5C with a second snd_cmd poked during the high byte.
      send_and_capture(16'h4A5C, 1'b1, got, rise, cc0);
      chk("wr_frames", got, 20'b1_0101_1100_0_1_0100_1010_0);
      chk("wr_high_byte", got[8:1], 8'h4A);
      chk("wr_low_byte", got[18:11], 8'h5C);
      chk("wr_cmplt_time", rise, 2180);
      chk("wr_cmplt_low_at_start", cc0, 0);
      lows = 0;
      repeat (400) begin
         @(negedge clk);
         if (!bus.TX) lows++;
      end
      chk("busy_no_extra_frame", lows, 0);
      chk("busy_cmplt_held", bus.cmd_cmplt, 1);

      // Response byte A5 from the bench UART.
      uart_bits(8'hA5);
      rx_drv = 1'b1;
      @(negedge clk);
      chk("rsp_before_stop_sample", bus.resp_cmplt, 0);
      repeat (B - 1) @(negedge clk);
      chk("rsp_cmplt", bus.resp_cmplt, 1);
      chk("rsp_value", bus.resp, 8'hA5);
      bus.clr_rdy = 1'b1;
      @(negedge clk);
      bus.clr_rdy = 1'b0;
      @(negedge clk);
      chk("clr_rdy_clears", bus.resp_cmplt, 0);
      chk("clr_rdy_keeps_resp", bus.resp, 8'hA5);

      // Loopback 0081: two responses, 00 then 81.
      loop_en = 1'b1;
      @(negedge clk);
      bus.cmd     = 16'h0081;
      bus.snd_cmd = 1'b1;
      @(negedge clk);
      bus.snd_cmd = 1'b0;
      chk("lb_cmplt_cleared", bus.cmd_cmplt, 0);
      rises = 0;
      first = 8'hFF;
      prev  = bus.resp_cmplt;
      for (int n = 0; n < 2400; n++) begin
         @(negedge clk);
         if (bus.resp_cmplt && !prev) begin
            rises++;
            if (rises == 1) first = bus.resp;
         end
         prev = bus.resp_cmplt;
      end
      chk("lb_rises", rises, 2);
      chk("lb_first_byte", first, 8'h00);
      chk("lb_last_byte", bus.resp, 8'h81);
      chk("lb_cmd_cmplt", bus.cmd_cmplt, 1);

      // Reset during the low byte's start bit.
      loop_en     = 1'b0;
      bus.cmd     = 16'h1234;
      bus.snd_cmd = 1'b1;
      @(negedge clk);
      bus.snd_cmd = 1'b0;
      repeat (10 * B + B / 2) @(negedge clk);
      chk("mr_low_start_bit", bus.TX, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_tx_high", bus.TX, 1);
      chk("mr_cmd_cmplt", bus.cmd_cmplt, 0);
      chk("mr_resp_cmplt", bus.resp_cmplt, 0);
      chk("mr_resp", bus.resp, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      repeat (1500) begin
         @(negedge clk);
         if (!bus.TX) lows++;
      end
      chk("mr_frame_abandoned", lows, 0);
      chk("mr_cmplt_stays_low", bus.cmd_cmplt, 0);

      send_and_capture(16'hC33C, 1'b0, got, rise, cc0);
      chk("post_rst_frames", got, 20'b1_0011_1100_0_1_1100_0011_0);
      chk("post_rst_cmplt_time", rise, 2180);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_comm_master
`default_nettype wire

// File: doc/comm_master.md
Name: comm_master

Overview:
- Host-side UART command master for the logic-analyzer system.
- Serializes a 16-bit host command as two 8N1 bytes, high byte first, onto TX.
- Deserializes the single 8-bit response byte returned on RX.
- Exposes completion/ready flags so a bench or host controller can sequence read/write/dump commands.

Parameters:
- BAUD_CNT, 109, clocks per UART bit period (921,600 baud at 100 MHz clk).

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  synchronous active-low reset
- cmd  in  16  command word; [15:8] sent first, [7:0] second
- snd_cmd  in  1  single-cycle pulse that starts a transmission
- TX  out  1  UART serial out, idles high
- RX  in  1  UART serial in, asynchronous to clk
- cmd_cmplt  out  1  both command bytes fully sent
- resp  out  8  last received response byte
- resp_cmplt  out  1  response byte valid
- clr_rdy  in  1  pulse that clears resp_cmplt

Behaviour:
- Reset: all outputs and state are cleared on the rst_n low clock edge.
  - TX=1, cmd_cmplt=0, resp_cmplt=0, resp=8'h00.
  - Baud/bit counters are zeroed; both FSMs return to IDLE.
- Reset mid-frame: TX returns high within one clock and the partial frame is abandoned.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_CNT clocks.
- TX FSM states: IDLE -> HIGH_BYTE -> LOW_BYTE -> IDLE.
- IDLE:
  - snd_cmd=1 latches cmd into a 16-bit shadow register and clears cmd_cmplt.
  - TX drives the start bit on the next clock edge.
- HIGH_BYTE sends shadow[15:8]. At the end of its stop bit, LOW_BYTE's start bit follows with no idle gap.
- LOW_BYTE sends shadow[7:0]. At the end of its stop bit:
  - The FSM returns to IDLE.
  - cmd_cmplt sets 20*BAUD_CNT clocks after snd_cmd was sampled.
- cmd_cmplt stays high until the next accepted snd_cmd or reset.
- snd_cmd while not IDLE is ignored. cmd changes after latching have no effect.
- RX path:
  - RX is double-flop synchronized; synchronizer flops reset to 1.
  - A synchronized falling edge in RX IDLE starts reception.
  - Each bit is sampled at mid-bit: first sample BAUD_CNT/2 clocks after the edge, then every BAUD_CNT clocks.
  - Eight data bits are shifted in LSB first.
  - The stop bit is sampled but not checked; a framing error is ignored and the byte is still delivered.
- After the stop-bit sample, resp updates with the received byte and resp_cmplt sets in the same cycle.
- resp_cmplt clears on clr_rdy=1 or on detection of a new start bit. If both occur in the same cycle as setting, setting wins.
- resp holds its value until the next received byte.
- TX and RX are fully independent; a response may arrive while a command is still transmitting.

Optional Feature:
- Macro: COMM_RESP_TIMEOUT_EN.
- Defined:
  - Adds output port resp_timeout (1 bit) and parameter TIMEOUT_CLKS (default 1,000,000).
  - A counter starts when cmd_cmplt sets.
  - resp_timeout asserts if resp_cmplt has not set within TIMEOUT_CLKS clocks.
  - resp_timeout clears on the next accepted snd_cmd or reset.
- Undefined: no port, no counter; behaviour is otherwise identical.

Decomposition:
- Package comm_pkg holds:
  - enum tx_state_t {TX_IDLE, TX_HIGH, TX_LOW};
  - enum rx_state_t {RX_IDLE, RX_RECV};
  - localparam BAUD_CNT_DFLT=109.
- Sub-module comm_uart_rx (synchronizer, mid-bit sampler, shift register, rdy output).
- Byte transmit and command sequencing stay in comm_master.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks -> TX=1, cmd_cmplt=0, resp_cmplt=0, resp=00.
- Write command:
  - Stimulus: cmd=16'h4A5C, snd_cmd pulse.
  - Required: TX carries frames 0x4A then 0x5C with no gap.
  - Required: cmd_cmplt rises exactly 20*109 clocks later.
- Busy guard:
  - Stimulus: second snd_cmd with cmd=16'hFFFF during the first byte.
  - Required: only 0x4A/0x5C transmitted; cmd_cmplt set once.
- Response:
  - Stimulus: bench UART sends 0xA5 on RX.
  - Required: resp=A5 and resp_cmplt=1 after the stop-bit sample.
  - Stimulus: clr_rdy pulse. Required: resp_cmplt=0, resp stays A5.
- Loopback: tie TX to RX, send 16'h0081 -> resp_cmplt pulses for byte 0x00, then ends with resp=81.
- Mid-frame reset: assert rst_n=0 during the low byte -> TX=1 next clock, cmd_cmplt stays 0. A fresh snd_cmd then transmits normally.
